// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// boot_loader : copies the boot ROM into main memory with a running XOR
//               checksum, holding the CPU in reset until the copy completes.
// Revision    : 1.0  initial release
// ============================================================================
module boot_loader #(
  parameter int ROM_WORDS = 8,
  parameter int AW        = 12,
  parameter int DEST_BASE = 0
) (
  input  logic          romclk,
  input  logic          rst,
  input  logic          reboot,
  output logic          rom_cs,
  output logic          rom_we,
  output logic [2:0]    rom_addr,
  input  logic [15:0]   rom_dout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          cpu_hold,
  output logic          done,
  output logic [15:0]   csum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0]    c_last = 3'(ROM_WORDS - 1);
  localparam logic [AW-1:0] c_base = AW'(DEST_BASE);

  state_t        r_state;
  logic [2:0]    r_idx;
  logic          r_rom_cs;
  logic [2:0]    r_rom_addr;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_done;
  logic [15:0]   r_csum;

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_rom_cs    <= 1'b0;
      r_rom_addr  <= 3'd0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_csum      <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RD;
        S_RD: begin
          r_rom_cs   <= 1'b1;
          r_rom_addr <= r_idx;
          r_state    <= S_CAP;
        end
        S_CAP: begin
          r_mem_wdata <= rom_dout;
          r_csum      <= r_csum ^ rom_dout;
          r_rom_cs    <= 1'b0;
          r_mem_req   <= 1'b1;
          r_mem_addr  <= c_base + AW'(r_idx);
          r_state     <= S_WR;
        end
        S_WR: begin
          // Request, address and data stay frozen until the ack edge.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_idx == c_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_RD;
            end
          end
        end
        S_DONE: begin
          if (reboot) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_csum     <= 16'h0000;
          end else begin
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_cs    = r_rom_cs;
  assign rom_we    = 1'b0;
  assign rom_addr  = r_rom_addr;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign csum      = r_csum;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_boot_loader : directed self-checking bench for boot_loader.
// Revision       : 1.0  initial release
// ============================================================================
module tb_boot_loader;

  logic        romclk;
  logic        rst, reboot, mem_ack;
  logic        rom_cs, rom_we, mem_req, mem_we, cpu_hold, done;
  logic [2:0]  rom_addr;
  logic [15:0] rom_dout, mem_wdata, csum;
  logic [11:0] mem_addr;

  logic        rst_b, reboot_b, mem_ack_b;
  logic        rom_cs_b, rom_we_b, mem_req_b, mem_we_b, cpu_hold_b, done_b;
  logic [2:0]  rom_addr_b;
  logic [15:0] rom_dout_b, mem_wdata_b, csum_b;
  logic [11:0] mem_addr_b;

  logic [15:0] rom [0:7];
  logic [11:0] wa [0:31];
  logic [15:0] wd [0:31];
  logic [11:0] wa_b [0:31];
  logic [15:0] wd_b [0:31];
  int          wn, wn_b;
  int          errors, checks;

  boot_loader u_dut (
    .romclk(romclk), .rst(rst), .reboot(reboot),
    .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .cpu_hold(cpu_hold), .done(done), .csum(csum)
  );

  boot_loader #(.ROM_WORDS(3), .AW(12), .DEST_BASE(32'h100)) u_small (
    .romclk(romclk), .rst(rst_b), .reboot(reboot_b),
    .rom_cs(rom_cs_b), .rom_we(rom_we_b), .rom_addr(rom_addr_b), .rom_dout(rom_dout_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ack(mem_ack_b), .cpu_hold(cpu_hold_b), .done(done_b), .csum(csum_b)
  );

  initial romclk = 1'b0;
  always #5 romclk = ~romclk;

  // ROM data is only valid while selected; zero otherwise exposes mistimed capture.
  assign rom_dout   = rom_cs   ? rom[rom_addr]   : 16'h0000;
  assign rom_dout_b = rom_cs_b ? rom[rom_addr_b] : 16'h0000;

  always @(posedge romclk) begin
    if (mem_req === 1'b1 && mem_ack === 1'b1 && wn < 32) begin
      wa[wn] = mem_addr;
      wd[wn] = mem_wdata;
      wn = wn + 1;
    end
    if (mem_req_b === 1'b1 && mem_ack_b === 1'b1 && wn_b < 32) begin
      wa_b[wn_b] = mem_addr_b;
      wd_b[wn_b] = mem_wdata_b;
      wn_b = wn_b + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic restart();
    @(negedge romclk);
    rst = 1'b1;
    @(negedge romclk);
    wn  = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reboot = 1'b0; mem_ack = 1'b1;
    rst_b = 1'b1; reboot_b = 1'b0; mem_ack_b = 1'b1;
    #1;
    checks++;
    if ({rom_cs, rom_we, rom_addr, mem_req, mem_we, mem_addr, mem_wdata, cpu_hold, done, csum}
        !== {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: cs=%b we=%b ra=%h req=%b mwe=%b ma=%h wd=%h hold=%b done=%b csum=%h",
               rom_cs, rom_we, rom_addr, mem_req, mem_we, mem_addr, mem_wdata, cpu_hold, done, csum);
    end
  endtask

  task automatic test_copy();
    @(negedge romclk);
    wn  = 0;
    rst = 1'b0;
    @(posedge romclk); #1;
    checks++;
    if (rom_cs !== 1'b0) begin errors++; $display("FAIL copy_edge1_cs: got %b want 0", rom_cs); end
    @(posedge romclk); #1;
    checks++;
    if ({rom_cs, rom_addr, rom_we} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL copy_edge2_cs: cs=%b addr=%h we=%b want 1 0 0", rom_cs, rom_addr, rom_we);
    end
    @(posedge romclk); #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h000, 16'hF200}) begin
      errors++; $display("FAIL copy_first_req: req=%b we=%b addr=%h data=%h", mem_req, mem_we, mem_addr, mem_wdata);
    end
    repeat (22) @(posedge romclk);
    #1;
    checks++;
    if ({done, cpu_hold} !== 2'b01) begin
      errors++; $display("FAIL copy_edge25: done=%b hold=%b want 0 1", done, cpu_hold);
    end
    @(posedge romclk); #1;
    checks++;
    if ({done, cpu_hold, csum} !== {1'b1, 1'b0, 16'hDE0F}) begin
      errors++; $display("FAIL copy_edge26: done=%b hold=%b csum=%h want 1 0 DE0F", done, cpu_hold, csum);
    end
    checks++;
    if (wn !== 8) begin errors++; $display("FAIL copy_write_count: got %0d want 8", wn); end
    for (int i = 0; i < 8 && i < wn; i++) begin
      checks++;
      if (wa[i] !== 12'(i) || wd[i] !== rom[i]) begin
        errors++; $display("FAIL copy_word%0d: addr=%h data=%h want %h %h", i, wa[i], wd[i], 12'(i), rom[i]);
      end
    end
  endtask

  task automatic test_stall();
    restart();
    repeat (12) @(posedge romclk);
    @(negedge romclk);
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge romclk); #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h003, 16'h1007}) begin
        errors++; $display("FAIL stall_hold%0d: req=%b we=%b addr=%h data=%h want 1 1 003 1007",
                           i, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    @(negedge romclk);
    mem_ack = 1'b1;
    repeat (13) @(posedge romclk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL stall_edge30: done=%b want 0", done); end
    @(posedge romclk); #1;
    checks++;
    if ({done, csum} !== {1'b1, 16'hDE0F}) begin
      errors++; $display("FAIL stall_edge31: done=%b csum=%h want 1 DE0F", done, csum);
    end
    checks++;
    if (wn !== 8 || wa[3] !== 12'h003 || wd[3] !== 16'h1007 || wa[4] !== 12'h004) begin
      errors++; $display("FAIL stall_writes: count=%0d w3=%h/%h w4=%h", wn, wa[3], wd[3], wa[4]);
    end
  endtask

  task automatic test_stray_ack();
    bit fin;
    fin = 1'b0;
    restart();
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge romclk);
      mem_ack = c[0];
      @(posedge romclk); #1;
      if (done === 1'b1) fin = 1'b1;
    end
    mem_ack = 1'b1;
    checks++;
    if (!fin) begin errors++; $display("FAIL stray_timeout: done=%b want 1 within 200 cycles", done); end
    checks++;
    if (wn !== 8 || csum !== 16'hDE0F) begin
      errors++; $display("FAIL stray_summary: count=%0d csum=%h want 8 DE0F", wn, csum);
    end
    for (int i = 0; i < 8 && i < wn; i++) begin
      checks++;
      if (wa[i] !== 12'(i) || wd[i] !== rom[i]) begin
        errors++; $display("FAIL stray_word%0d: addr=%h data=%h want %h %h", i, wa[i], wd[i], 12'(i), rom[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    repeat (15) @(posedge romclk);
    @(negedge romclk);
    checks++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 12'h004, 16'hF400}) begin
      errors++; $display("FAIL midrst_wr4: req=%b addr=%h data=%h want 1 004 F400", mem_req, mem_addr, mem_wdata);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rom_cs, rom_addr, mem_req, mem_we, mem_addr, mem_wdata, cpu_hold, done, csum}
        !== {1'b0, 3'd0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL midrst_async: cs=%b ra=%h req=%b we=%b ma=%h wd=%h hold=%b csum=%h",
                         rom_cs, rom_addr, mem_req, mem_we, mem_addr, mem_wdata, cpu_hold, csum);
    end
    @(negedge romclk);
    wn  = 0;
    rst = 1'b0;
    repeat (26) @(posedge romclk);
    #1;
    checks++;
    if ({done, csum} !== {1'b1, 16'hDE0F} || wn !== 8 || wa[0] !== 12'h000 || wd[0] !== 16'hF200) begin
      errors++; $display("FAIL midrst_recopy: done=%b csum=%h count=%0d w0=%h/%h", done, csum, wn, wa[0], wd[0]);
    end
  endtask

  task automatic test_reboot();
    @(negedge romclk);
    reboot = 1'b1;
    wn = 0;
    @(posedge romclk); #1;
    checks++;
    if ({cpu_hold, done, csum} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL reboot_edge: hold=%b done=%b csum=%h want 1 0 0000", cpu_hold, done, csum);
    end
    @(negedge romclk);
    reboot = 1'b0;
    @(posedge romclk); #1;
    checks++;
    if (rom_cs !== 1'b0) begin errors++; $display("FAIL reboot_idle_cs: got %b want 0", rom_cs); end
    @(negedge romclk);
    reboot = 1'b1;
    @(posedge romclk); #1;
    checks++;
    if ({rom_cs, rom_addr, cpu_hold} !== {1'b1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL reboot_in_rd: cs=%b addr=%h hold=%b want 1 0 1", rom_cs, rom_addr, cpu_hold);
    end
    @(negedge romclk);
    reboot = 1'b0;
    repeat (23) @(posedge romclk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reboot_edge25: done=%b want 0", done); end
    @(posedge romclk); #1;
    checks++;
    if ({done, cpu_hold, csum} !== {1'b1, 1'b0, 16'hDE0F} || wn !== 8) begin
      errors++; $display("FAIL reboot_recopy: done=%b hold=%b csum=%h count=%0d", done, cpu_hold, csum, wn);
    end
  endtask

  task automatic test_small();
    @(negedge romclk);
    wn_b  = 0;
    rst_b = 1'b0;
    repeat (10) @(posedge romclk);
    #1;
    checks++;
    if ({done_b, cpu_hold_b} !== 2'b01) begin
      errors++; $display("FAIL small_edge10: done=%b hold=%b want 0 1", done_b, cpu_hold_b);
    end
    @(posedge romclk); #1;
    checks++;
    if ({done_b, cpu_hold_b, csum_b, rom_we_b, mem_we_b} !== {1'b1, 1'b0, 16'h4A00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL small_edge11: done=%b hold=%b csum=%h rwe=%b mwe=%b want 1 0 4A00 0 0",
                         done_b, cpu_hold_b, csum_b, rom_we_b, mem_we_b);
    end
    checks++;
    if (wn_b !== 3) begin errors++; $display("FAIL small_count: got %0d want 3", wn_b); end
    for (int i = 0; i < 3 && i < wn_b; i++) begin
      checks++;
      if (wa_b[i] !== 12'h100 + 12'(i) || wd_b[i] !== rom[i]) begin
        errors++; $display("FAIL small_word%0d: addr=%h data=%h want %h %h", i, wa_b[i], wd_b[i], 12'h100 + 12'(i), rom[i]);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; wn = 0; wn_b = 0;
    rom[0] = 16'hF200; rom[1] = 16'h4000; rom[2] = 16'hF800; rom[3] = 16'h1007;
    rom[4] = 16'hF400; rom[5] = 16'h3008; rom[6] = 16'h4000; rom[7] = 16'h0000;
    test_reset();
    test_copy();
    test_stall();
    test_stray_ack();
    test_reset_mid();
    test_reboot();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_loader.md
# boot_loader

Boot-time copier between the 8-word boot ROM and main memory. After reset it reads every ROM word in order, writes each one into main memory through a request/acknowledge port, and keeps a running XOR checksum. It holds the CPU in reset until the last write is acknowledged, then releases it. It is the ROM's only reader during boot; the CPU sees memory only after `done`.

## Interface
Parameters:
- `ROM_WORDS`, 8: number of ROM words copied; must be between 1 and 8.
- `AW`, 12: main-memory address width.
- `DEST_BASE`, 0: main-memory address of ROM word 0.

Ports:
- `romclk` in, 1: clock. All state changes on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `reboot` in, 1: restarts the copy; acted on only in DONE.
- `rom_cs` out, 1: ROM chip select.
- `rom_we` out, 1: ROM write enable; constant 0.
- `rom_addr` out, 3: ROM word index.
- `rom_dout` in, 16: ROM read data; valid the cycle after `rom_cs`/`rom_addr` are driven.
- `mem_req` out, 1: memory write request.
- `mem_we` out, 1: memory write enable; equals `mem_req`.
- `mem_addr` out, AW: `DEST_BASE + index`, truncated to AW bits.
- `mem_wdata` out, 16: word being written.
- `mem_ack` in, 1: memory accepted the write; sampled only while `mem_req` is 1.
- `cpu_hold` out, 1: 1 keeps the CPU in reset.
- `done` out, 1: copy complete.
- `csum` out, 16: XOR of all words copied so far.

## Operation
- All outputs are registered.
- Reset values: `rom_cs` 0, `rom_we` 0, `rom_addr` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `done` 0, `csum` 0. Internal index 0, state IDLE.
- IDLE: moves to RD on the first edge after reset deasserts. No handshake is needed.
- RD: drive `rom_cs`=1 and `rom_addr`=index; go to CAP.
- CAP: capture `rom_dout` into `mem_wdata`; `csum` ^= `rom_dout`; `rom_cs`=0; set `mem_req`/`mem_we`=1 and `mem_addr`; go to WR.
- WR: hold request, address and data stable until `mem_ack`=1 is sampled at an edge.
  - On that edge, drop `mem_req`/`mem_we`.
  - If index = ROM_WORDS-1: go to DONE.
  - Otherwise: index+1, go to RD.
- DONE: `cpu_hold`=0, `done`=1; all ROM and memory signals idle.
  - `reboot`=1 at an edge: go to IDLE, `cpu_hold`=1, `done`=0, `csum`=0, index=0.
  - `csum` holds its final value until reboot or reset.
- `reboot` is ignored in IDLE, RD, CAP and WR.
- `mem_ack` is ignored when `mem_req`=0; a stray ack neither skips nor repeats a word.
- Index arithmetic is 3-bit with no wrap. The compare against ROM_WORDS-1 ends the sequence, so ROM word 7 is read only when ROM_WORDS=8.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). `mem_req` drops without waiting for `mem_ack`. The copy restarts from index 0 after reset deasserts.

## Timing
- Per word: RD (1 cycle) + CAP (1 cycle) + WR (1 + ack wait cycles).
- With `mem_ack` tied to 1, each word takes 3 cycles. For ROM_WORDS=8:
  - first `rom_cs` at edge 2 after reset deasserts;
  - `done`/`cpu_hold` change at edge 26.
- `mem_ack` stalls extend WR only; RD/CAP timing is unchanged.
- `rom_addr` is stable for both RD and CAP, so the ROM's read latch stays valid when sampled.
- After `reboot` is sampled in DONE, `cpu_hold`=1 on the same edge; the next `rom_cs` follows 2 edges later.

## Test plan
- Reset, ROM model = F200,4000,F800,1007,F400,3008,4000,0000, `mem_ack`=1 -> memory writes 0..7 carry exactly those words in order; `done`=1 and `cpu_hold`=0 at edge 26; `csum`=DE0F.
- `mem_ack` held low for 5 cycles on word 3 -> `mem_addr`=DEST_BASE+3 and `mem_wdata`=1007 stay stable throughout; `done` is delayed by exactly 5 cycles; no duplicate writes.
- `mem_ack` pulsed while `mem_req`=0 (during RD/CAP) -> no state change; word sequence and `csum` unchanged.
- `rst` asserted during WR of word 4 -> outputs reach reset values immediately; after release, the copy restarts at word 0 and finishes with `csum`=DE0F.
- `reboot` pulsed in DONE -> `cpu_hold`=1 and `csum`=0; full copy repeats; `reboot` pulsed during RD -> ignored.
- ROM_WORDS=3, DEST_BASE=0x100 -> writes 0x100..0x102 = F200,4000,F800; `csum`=4A00; `done` at edge 11.
